// File: rtl/uart_pkg.sv
// Shared UART constants for the 12 MHz design, plus receiver state encoding.
// Frame defaults are common to the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 12_000_000;
  localparam int unsigned BAUD_RATE    = 9600;
  localparam int unsigned BAUD_RATIO   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned STOP_BITS    = 2;
  localparam int unsigned WORD_WIDTH   = 16;
  localparam int unsigned WORD_TIMEOUT = 20;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: rx synchroniser, start/data/stop FSM and bit timer.
// byte_valid/frame_err/start are single-cycle strobes raised in the deciding cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_2_CLOCK_RATIO = BAUD_RATIO,
  parameter int unsigned UART_DATA_BITS     = DATA_BITS,
  parameter int unsigned UART_STOP_BITS     = STOP_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] byte_out,
  output logic                      byte_valid,
  output logic                      frame_err,
  output logic                      busy,
  output logic                      start
);

  localparam int unsigned CNT_W    = clog2_min1(BAUD_2_CLOCK_RATIO);
  localparam int unsigned MAX_BITS = (UART_DATA_BITS > UART_STOP_BITS) ? UART_DATA_BITS
                                                                       : UART_STOP_BITS;
  localparam int unsigned IDX_W    = clog2_min1(MAX_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_2_CLOCK_RATIO / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(UART_STOP_BITS - 1);

  logic                      rx_meta, rxs, rxs_d;
  rx_state_e                 state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      fall, tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
    end
  end

  assign fall = rxs_d & ~rxs;
  assign tick = (cnt == '0);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    start      = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          state_n = RX_START;
          cnt_n   = HALF_LOAD;
          start   = 1'b1;
        end
      end
      RX_START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          state_n = RX_IDLE;
        end else begin
          state_n = RX_DATA;
          cnt_n   = FULL_LOAD;
          idx_n   = '0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n = {rxs, shreg[UART_DATA_BITS-1:1]};
          cnt_n   = FULL_LOAD;
          if (idx == LAST_DATA) begin
            state_n = RX_STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          cnt_n = FULL_LOAD;
          if (!rxs) begin
            frame_err = 1'b1;
            state_n   = RX_IDLE;
          end else if (idx == LAST_STOP) begin
            byte_valid = 1'b1;
            state_n    = RX_IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign busy     = (state != RX_IDLE);
  assign byte_out = shreg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: assembles received bytes LSB-first into words and drops
// a partial word after a long idle gap or a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_2_CLOCK_RATIO = BAUD_RATIO,
  parameter int unsigned UART_DATA_BITS     = DATA_BITS,
  parameter int unsigned UART_STOP_BITS     = STOP_BITS,
  parameter int unsigned OUTPUT_DATA_WIDTH  = WORD_WIDTH,
  parameter int unsigned WORD_TIMEOUT_BITS  = WORD_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int unsigned NUM_BYTES = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
  localparam int unsigned BIDX_W    = clog2_min1(NUM_BYTES);
  localparam int unsigned TO_CYCLES = WORD_TIMEOUT_BITS * BAUD_2_CLOCK_RATIO;
  localparam int unsigned TO_W      = clog2_min1(TO_CYCLES);

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYCLES - 1);

  logic [UART_DATA_BITS-1:0]    byte_data;
  logic                         byte_valid, byte_err, start;
  logic [OUTPUT_DATA_WIDTH-1:0] word_buf, word_next;
  logic [BIDX_W-1:0]            byte_idx;
  logic [TO_W-1:0]              to_cnt;

  uart_rx_byte #(
    .BAUD_2_CLOCK_RATIO(BAUD_2_CLOCK_RATIO),
    .UART_DATA_BITS    (UART_DATA_BITS),
    .UART_STOP_BITS    (UART_STOP_BITS)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_out  (byte_data),
    .byte_valid(byte_valid),
    .frame_err (byte_err),
    .busy      (busy),
    .start     (start)
  );

  always_comb begin
    word_next = word_buf;
    word_next[byte_idx * UART_DATA_BITS +: UART_DATA_BITS] = byte_data;
  end

  // Start detection takes priority over timeout expiry, keeping the partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_buf   <= '0;
      byte_idx   <= '0;
      to_cnt     <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= byte_err;
      if (start) begin
        to_cnt <= '0;
      end else if ((byte_idx != '0) && !busy) begin
        if (to_cnt == TO_LAST) begin
          to_cnt   <= '0;
          byte_idx <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
      if (byte_err) begin
        byte_idx <= '0;
      end else if (byte_valid) begin
        if (byte_idx == LAST_BYTE) begin
          data_out   <= word_next;
          data_valid <= 1'b1;
          byte_idx   <= '0;
        end else begin
          word_buf <= word_next;
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at a shortened bit period (R = 100 clocks).
// Table-driven multi-byte frames plus hand-written false-start and reset sequences.
module tb_uart_rx;

  localparam int R   = 100;
  localparam int CLK = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] data_out;
  logic        data_valid, frame_err, busy;

  always #(CLK / 2) clk = ~clk;

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(R),
    .UART_DATA_BITS    (8),
    .UART_STOP_BITS    (2),
    .OUTPUT_DATA_WIDTH (16),
    .WORD_TIMEOUT_BITS (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  int          n_err = 0;
  logic [15:0] last_word = '0;
  time         t_valid = 0;
  time         t_fall = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid   = n_valid + 1;
      last_word = data_out;
      t_valid   = $time;
    end
    if (frame_err) n_err = n_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    t_fall = $time;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = 1'b1;
    repeat (per) @(negedge clk);
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (per) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [31:0] bytes;   // byte k at [8k+7:8k], sent first to last
    int          n;
    logic [3:0]  bad;     // bytes whose second stop bit is driven low
    int          per;
    int          idle0;   // idle bit periods after the first byte
    logic [15:0] word;
    int          nvalid;
    int          nerr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          v0, e0;
    logic [7:0]  bcur;
    logic [7:0]  pb;

    vecs[0] = '{32'h0000_1234, 2, 4'b0000, R,   0,  16'h1234, 1, 0};
    vecs[1] = '{32'h0056_7834, 3, 4'b0001, R,   0,  16'h5678, 1, 1};
    vecs[2] = '{32'h5678_2211, 4, 4'b0010, R,   0,  16'h5678, 1, 1};
    vecs[3] = '{32'h00AB_CDAA, 3, 4'b0000, R,   25, 16'hABCD, 1, 0};
    vecs[4] = '{32'h0000_A55A, 2, 4'b0000, 97,  0,  16'hA55A, 1, 0};
    vecs[5] = '{32'h0000_A55A, 2, 4'b0000, 103, 0,  16'hA55A, 1, 0};
    vecs[6] = '{32'h0403_0201, 4, 4'b0000, R,   0,  16'h0403, 2, 0};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // False start: rx low 40 cycles (shorter than half a bit)
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_sync", 32'(busy), 32'h0);
    @(negedge clk);
    check("busy_after_sync", 32'(busy), 32'h1);
    repeat (37) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    check("false_start_busy_clear", 32'(busy), 32'h0);
    repeat (200) @(negedge clk);
    check("false_start_no_valid", 32'(n_valid - v0), 32'h0);
    check("false_start_no_err", 32'(n_err - e0), 32'h0);
    send_byte(8'h34, R, 1'b0);
    send_byte(8'h12, R, 1'b0);
    repeat (3 * R) @(negedge clk);
    check("after_false_start_count", 32'(n_valid - v0), 32'h1);
    check("after_false_start_word", 32'(last_word), 32'h1234);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      repeat (3 * R) @(negedge clk);
      v0 = n_valid;
      e0 = n_err;
      for (int k = 0; k < vecs[v].n; k++) begin
        bcur = vecs[v].bytes[k*8 +: 8];
        send_byte(bcur, vecs[v].per, vecs[v].bad[k]);
        if (k == 0 && vecs[v].idle0 > 0) repeat (vecs[v].idle0 * vecs[v].per) @(negedge clk);
      end
      repeat (3 * R) @(negedge clk);
      check($sformatf("vec%0d_valid_count", v), 32'(n_valid - v0), 32'(vecs[v].nvalid));
      check($sformatf("vec%0d_err_count", v), 32'(n_err - e0), 32'(vecs[v].nerr));
      check($sformatf("vec%0d_word", v), 32'(last_word), 32'(vecs[v].word));
      check($sformatf("vec%0d_data_out_held", v), 32'(data_out), 32'(vecs[v].word));
      check($sformatf("vec%0d_busy_idle", v), 32'(busy), 32'h0);
      if (vecs[v].per == R)
        check($sformatf("vec%0d_valid_latency", v), 32'(t_valid - t_fall), 32'(1053 * CLK));
    end

    // Reset during data bit 3, with one byte of a word already held
    send_byte(8'h99, R, 1'b0);
    pb = 8'hEF;
    @(negedge clk);
    rx = 1'b0;
    repeat (R) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      repeat (R) @(negedge clk);
    end
    rx = pb[3];
    repeat (R / 2) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_data_valid", 32'(data_valid), 32'h0);
    check("mid_rst_frame_err", 32'(frame_err), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (3 * R) @(negedge clk);
    v0 = n_valid;
    e0 = n_err;
    send_byte(8'hEF, R, 1'b0);
    send_byte(8'hBE, R, 1'b0);
    repeat (3 * R) @(negedge clk);
    check("post_rst_count", 32'(n_valid - v0), 32'h1);
    check("post_rst_word", 32'(last_word), 32'hBEEF);
    check("post_rst_err", 32'(n_err - e0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
